muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for the HI/LO multiply/divide resource of the 54-instruction core. Accepts one
//  MULT/MULTU/DIV/DIVU per start pulse from the decode stage, runs an iterative shift-add or
//  restoring-divide engine, and owns the HI/LO registers (also written by MTHI/MTLO).
//  It drives busy so the pipeline stalls MFHI/MFLO and new muldiv ops until the result lands.
// PARAMETERS
//  WIDTH   32   operand width; HI/LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk      in   1      clock, rising edge
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      issue op; sampled only while state==IDLE
//  op       in   2      muldiv_pkg::md_op_t: MULT=00, MULTU=01, DIV=10, DIVU=11
//  rs_data  in   WIDTH  multiplicand / dividend
//  rt_data  in   WIDTH  multiplier / divisor
//  abort    in   1      exception flush; kills in-flight op
//  mthi     in   1      write wdata to HI (MTHI)
//  mtlo     in   1      write wdata to LO (MTLO)
//  wdata    in   WIDTH  MTHI/MTLO data
//  busy     out  1      1 while state != IDLE
//  done     out  1      one-cycle pulse: HI/LO now hold new result
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, all working regs 0.
//  FSM IDLE -> CALC -> FIX -> IDLE.
//   IDLE: start=1 latches |rs|,|rt| (signed ops) or raw (unsigned ops), sign flags, op; ->CALC,
//         iteration counter=0. DIV/DIVU with rt_data==0: skip CALC, ->FIX directly.
//   CALC: one iteration per cycle; counter 0..WIDTH-1; after count WIDTH-1 ->FIX.
//         Mult: 2*WIDTH-bit accumulator, add-if-LSB then shift right.
//         Div: restoring; shift {rem,quo} left 1, trial subtract, keep if non-negative.
//   FIX: sign correction, write HI/LO on the edge leaving FIX; ->IDLE; done=1 next cycle.
//  Latency: start edge k -> busy=1 in cycles k+1..k+WIDTH+1 -> done=1 and new HI/LO at k+WIDTH+2
//   (34 cycles at WIDTH=32). Divide-by-zero: 2 cycles.
//  Results: MULT/MULTU {hi,lo}=full 2*WIDTH product; signed negated if operand signs differ.
//   DIV/DIVU lo=quotient, hi=remainder; signed quotient negative iff signs differ, remainder
//   takes dividend sign. Divide-by-zero: lo={WIDTH{1'b1}}, hi=rs_data (no trap).
//   Most-negative / -1 signed divide: lo=0x8000_0000, hi=0 (wraps, no overflow flag).
//  start while busy: ignored (decode must stall on busy). done never coincides with busy.
//  mthi/mtlo: applied on the edge only when state==IDLE; dropped while busy. Same-cycle start and
//   mthi/mtlo in IDLE: write applies now, result overwrites at completion.
//  abort: highest priority over start; any state ->IDLE next edge, HI/LO unchanged, no done.
//   abort in IDLE with start=1: start dropped.
//  Async reset mid-operation: immediate return to reset values; op lost.
// CONFIGURATION
//  MULDIV_FAST_MULT_EN defined: MULT/MULTU use a single-cycle combinational WIDTHxWIDTH multiplier,
//   IDLE->FIX directly; done at k+2. Divide path unchanged.
//  Not defined: MULT/MULTU take the iterative CALC path (WIDTH+2 cycles).
// STRUCTURE
//  muldiv_pkg: md_op_t enum, md_state_t {IDLE,CALC,FIX}, MD_CNT_W=$clog2(WIDTH) constant,
//   helpers is_signed(op), is_div(op).
//  Sub-module muldiv_step: purely combinational one-iteration datapath (mult add-shift or
//   div trial-subtract) selected by is_div; muldiv_ctrl holds FSM, counter, sign flags, HI/LO.
// TESTING
//  MULTU 0xFFFF_FFFF x 0xFFFF_FFFF -> done at +34: hi=0xFFFF_FFFE, lo=0x0000_0001; busy 33 cycles.
//  MULT -3 x 7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; with MULDIV_FAST_MULT_EN done at +2.
//  DIV -7 / 2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIVU 100/7 -> lo=14, hi=2.
//  DIVU 5/0 -> done at +2, lo=0xFFFF_FFFF, hi=5; DIV 0x8000_0000/-1 -> lo=0x8000_0000, hi=0.
//  start DIV, abort at cycle 10 -> IDLE next edge, no done, HI/LO keep prior; new start accepted.
//  mthi 0x1234 while busy -> hi unchanged; mtlo 0xABCD in IDLE -> lo=0xABCD next cycle;
//   rst_n low mid-CALC -> hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

   localparam int unsigned MD_WIDTH = 32;
   localparam int unsigned MD_CNT_W = $clog2(MD_WIDTH);

   typedef enum logic [1:0] {
      MdMult  = 2'b00,
      MdMultu = 2'b01,
      MdDiv   = 2'b10,
      MdDivu  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StCalc = 2'b01,
      StFix  = 2'b10
   } md_state_t;

   function automatic logic is_signed(md_op_t op);
      return (op == MdMult) || (op == MdDiv);
   endfunction

   function automatic logic is_div(md_op_t op);
      return (op == MdDiv) || (op == MdDivu);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Decode-side issue/result bundle for the multiply/divide sequencer.
interface muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   import muldiv_pkg::*;

   logic             start;
   md_op_t           op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             abort;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_data, rt_data, abort, mthi, mtlo, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data, abort, mthi, mtlo, wdata,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the muldiv engine: shift-add multiply or restoring divide.
module muldiv_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             ge;

   always_comb begin
      sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      rem_sh = {acc_hi, acc_lo[WIDTH-1]};
      ge     = rem_sh >= {1'b0, opnd};
      // Remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
      diff   = rem_sh[WIDTH-1:0] - opnd;
      if (is_div) begin
         nxt_hi = ge ? diff : rem_sh[WIDTH-1:0];
         nxt_lo = {acc_lo[WIDTH-2:0], ge};
      end else begin
         nxt_hi = sum[WIDTH:1];
         nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, operand latch, sign fix-up and HI/LO ownership.
// Build option MULDIV_FAST_MULT_EN: single-cycle multiplier, MULT/MULTU go IDLE->FIX.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input logic     clk,
   input logic     rst_n,
   muldiv_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH);

   md_state_t        state_q, state_d;
   md_op_t           op_q, op_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0]   rs_abs, rt_abs;
   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   logic [2*WIDTH-1:0] prod_raw, prod_neg;

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .is_div (is_div(op_q)),
      .acc_hi (acc_hi_q),
      .acc_lo (acc_lo_q),
      .opnd   (opnd_q),
      .nxt_hi (step_hi),
      .nxt_lo (step_lo)
   );

   always_comb begin
      rs_abs = (is_signed(bus.op) && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
      rt_abs = (is_signed(bus.op) && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
   end

`ifdef MULDIV_FAST_MULT_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, rs_abs} * {{WIDTH{1'b0}}, rt_abs};
`endif

   // Engine works on magnitudes; signs are restored here. Divide-by-zero passes through raw.
   always_comb begin
      prod_raw = {acc_hi_q, acc_lo_q};
      prod_neg = -prod_raw;
      fix_hi   = acc_hi_q;
      fix_lo   = acc_lo_q;
      if (dz_q) begin
         fix_hi = acc_hi_q;
         fix_lo = acc_lo_q;
      end else if (is_div(op_q)) begin
         fix_lo = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
         fix_hi = sa_q ? -acc_hi_q : acc_hi_q;
      end else if (sa_q ^ sb_q) begin
         {fix_hi, fix_lo} = prod_neg;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opnd_d   = opnd_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      case (state_q)
         StIdle: begin
            if (bus.mthi) hi_d = bus.wdata;
            if (bus.mtlo) lo_d = bus.wdata;
            if (bus.start) begin
               op_d  = bus.op;
               sa_d  = is_signed(bus.op) & bus.rs_data[WIDTH-1];
               sb_d  = is_signed(bus.op) & bus.rt_data[WIDTH-1];
               cnt_d = '0;
               dz_d  = 1'b0;
               if (is_div(bus.op)) begin
                  if (bus.rt_data == '0) begin
                     dz_d     = 1'b1;
                     acc_hi_d = bus.rs_data;
                     acc_lo_d = '1;
                     state_d  = StFix;
                  end else begin
                     acc_hi_d = '0;
                     acc_lo_d = rs_abs;
                     opnd_d   = rt_abs;
                     state_d  = StCalc;
                  end
               end else begin
`ifdef MULDIV_FAST_MULT_EN
                  {acc_hi_d, acc_lo_d} = fast_prod;
                  state_d              = StFix;
`else
                  acc_hi_d = '0;
                  acc_lo_d = rt_abs;
                  opnd_d   = rs_abs;
                  state_d  = StCalc;
`endif
               end
            end
         end
         StCalc: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
         end
         StFix: begin
            hi_d    = fix_hi;
            lo_d    = fix_lo;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Flush beats everything, including a same-cycle start or HI/LO move.
      if (bus.abort) begin
         state_d = StIdle;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         op_q     <= MdMult;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opnd_q   <= opnd_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy = (state_q != StIdle);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl; honours MULDIV_FAST_MULT_EN for multiply latency.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
   localparam int MulLat = 2;
`else
   localparam int MulLat = 34;
`endif
   localparam int DivLat = 34;
   localparam int DzLat  = 2;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
      int          busy;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   vectors;
   int   miscompares;
   int   busy_run;
   exp_t sb[$];

   muldiv_if #(.WIDTH(32)) bus ();

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endfunction

   // Monitor: pops one expectation per done pulse.
   initial begin
      exp_t e;
      busy_run = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_run = 0;
         end else if (bus.busy) begin
            busy_run++;
         end else begin
            if (bus.done) begin
               check("done_no_busy", 32'(bus.busy), 32'd0);
               if (sb.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("hi", bus.hi, e.hi);
                  check("lo", bus.lo, e.lo);
                  check("done_cycle", 32'(cyc), 32'(e.cyc));
                  check("busy_cycles", 32'(busy_run), 32'(e.busy));
               end
            end
            busy_run = 0;
         end
      end
   end

   task automatic issue(md_op_t o, logic [31:0] a, logic [31:0] b, logic [31:0] eh,
                        logic [31:0] el, int lat, bit push);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = o;
      bus.rs_data = a;
      bus.rt_data = b;
      if (push) sb.push_back('{eh, el, cyc + lat, lat - 1});
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!bus.busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1, "timeout");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.op      = MdMult;
      bus.rs_data = '0;
      bus.rt_data = '0;
      bus.abort   = 1'b0;
      bus.mthi    = 1'b0;
      bus.mtlo    = 1'b0;
      bus.wdata   = '0;
      repeat (2) @(negedge clk);
      check("rst_hi", bus.hi, 32'h0);
      check("rst_lo", bus.lo, 32'h0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;

      issue(MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MulLat, 1);
      wait_idle();
      issue(MdMult, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MulLat, 1);
      wait_idle();
      issue(MdMult, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'h0, 32'd20, MulLat, 1);
      wait_idle();
      issue(MdDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivLat, 1);
      wait_idle();
      issue(MdDiv, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DivLat, 1);
      wait_idle();
      issue(MdDivu, 32'd100, 32'd7, 32'd2, 32'd14, DivLat, 1);
      wait_idle();
      issue(MdDivu, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DzLat, 1);
      wait_idle();
      issue(MdDiv, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, DzLat, 1);
      wait_idle();
      issue(MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DivLat, 1);
      wait_idle();

      // Abort mid-divide: no done, HI/LO keep the previous result.
      issue(MdDiv, 32'd1000, 32'd3, 32'h0, 32'h0, DivLat, 0);
      repeat (8) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_hi", bus.hi, 32'h0);
      check("abort_lo", bus.lo, 32'h8000_0000);
      issue(MdDivu, 32'd100, 32'd7, 32'd2, 32'd14, DivLat, 1);
      wait_idle();

      // MTHI while busy is dropped.
      issue(MdMultu, 32'd3, 32'd5, 32'h0, 32'd15, MulLat, 1);
      bus.mthi  = 1'b1;
      bus.wdata = 32'h1234;
      @(negedge clk);
      bus.mthi = 1'b0;
      if (MulLat > 2) check("mthi_busy_hi", bus.hi, 32'd2);
      wait_idle();

      @(negedge clk);
      bus.mtlo  = 1'b1;
      bus.wdata = 32'hABCD;
      @(negedge clk);
      bus.mtlo = 1'b0;
      check("mtlo_lo", bus.lo, 32'hABCD);
      check("mtlo_hi", bus.hi, 32'h0);

      // Async reset mid-divide clears everything at once.
      issue(MdDivu, 32'd63, 32'd9, 32'h0, 32'h0, DivLat, 0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_hi", bus.hi, 32'h0);
      check("arst_lo", bus.lo, 32'h0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(MdMult, 32'd2, 32'd3, 32'h0, 32'd6, MulLat, 1);
      wait_idle();
      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
